// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and load writeback.
// Each requester owns a one-entry holding slot; write-port outputs and pending map are register-based.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 5,
  parameter bit ZERO_REG_EN = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req0_valid,
  output logic                         req0_ready,
  input  logic [ADDR_WIDTH-1:0]        req0_addr,
  input  logic [DATA_WIDTH-1:0]        req0_data,
  input  logic                         req1_valid,
  output logic                         req1_ready,
  input  logic [ADDR_WIDTH-1:0]        req1_addr,
  input  logic [DATA_WIDTH-1:0]        req1_data,
  output logic [ADDR_WIDTH-1:0]        write_reg_address,
  output logic [DATA_WIDTH-1:0]        data,
  output logic                         reg_write,
  output logic                         grant_id,
  output logic [(2**ADDR_WIDTH)-1:0]   pending
);

  localparam int                    NUM_REGS  = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = '1;

  logic                  r_slot0_full, r_slot1_full;
  logic [ADDR_WIDTH-1:0] r_slot0_addr, r_slot1_addr;
  logic [DATA_WIDTH-1:0] r_slot0_data, r_slot1_data;
  logic                  r_prio;  // 0: req0 wins a tie, 1: req1 wins a tie

  logic                  w_grant0, w_grant1, w_any_grant;
  logic                  w_fill0, w_fill1;
  logic [ADDR_WIDTH-1:0] w_win_addr;
  logic [DATA_WIDTH-1:0] w_win_data;

  // Grant depends only on registered slot state and the pointer, never on valid.
  always_comb begin
    w_grant0    = r_slot0_full & (~r_slot1_full | ~r_prio);
    w_grant1    = r_slot1_full & (~r_slot0_full |  r_prio);
    w_any_grant = w_grant0 | w_grant1;
    w_win_addr  = w_grant1 ? r_slot1_addr : r_slot0_addr;
    w_win_data  = w_grant1 ? r_slot1_data : r_slot0_data;
  end

  assign req0_ready = ~reset & (~r_slot0_full | w_grant0);
  assign req1_ready = ~reset & (~r_slot1_full | w_grant1);

  // Writes to the zero register are accepted but never occupy a slot.
  assign w_fill0 = req0_valid & req0_ready & ~(ZERO_REG_EN && (req0_addr == ZERO_ADDR));
  assign w_fill1 = req1_valid & req1_ready & ~(ZERO_REG_EN && (req1_addr == ZERO_ADDR));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot0_full <= 1'b0;
      r_slot1_full <= 1'b0;
    end else begin
      if (w_fill0)       r_slot0_full <= 1'b1;
      else if (w_grant0) r_slot0_full <= 1'b0;
      if (w_fill1)       r_slot1_full <= 1'b1;
      else if (w_grant1) r_slot1_full <= 1'b0;
    end
  end

  // NOTE: slot payload is only meaningful while its full flag is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_fill0) begin
      r_slot0_addr <= req0_addr;
      r_slot0_data <= req0_data;
    end
    if (w_fill1) begin
      r_slot1_addr <= req1_addr;
      r_slot1_data <= req1_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write         <= 1'b0;
      write_reg_address <= '0;
      data              <= '0;
      grant_id          <= 1'b0;
      r_prio            <= 1'b0;
    end else begin
      reg_write <= w_any_grant;
      if (w_any_grant) begin
        write_reg_address <= w_win_addr;
        data              <= w_win_data;
        grant_id          <= w_grant1;
        r_prio            <= w_grant0;
      end
    end
  end

  always_comb begin
    pending = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      pending[r] = (r_slot0_full && (r_slot0_addr == ADDR_WIDTH'(r)))
                 | (r_slot1_full && (r_slot1_addr == ADDR_WIDTH'(r)))
                 | (reg_write    && (write_reg_address == ADDR_WIDTH'(r)));
    end
    if (ZERO_REG_EN) pending[NUM_REGS-1] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: two instances (zero-register discard on / off)
// share stimulus; monitors pop expected writes whenever reg_write is seen.
module tb_regfile_write_arbiter;

  typedef struct {
    logic [4:0]  addr;
    logic [63:0] data;
    logic        id;
  } wr_t;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr, req1_addr;
  logic [63:0] req0_data, req1_data;

  logic        a_req0_ready, a_req1_ready, a_reg_write, a_grant_id;
  logic [4:0]  a_addr;
  logic [63:0] a_data;
  logic [31:0] a_pending;
  logic        b_req0_ready, b_req1_ready, b_reg_write, b_grant_id;
  logic [4:0]  b_addr;
  logic [63:0] b_data;
  logic [31:0] b_pending;

  wr_t         q_a[$];
  wr_t         q_b[$];
  logic [63:0] mem_a [32];
  logic [63:0] mem_b [32];
  int          checks = 0;
  int          errors = 0;

  regfile_write_arbiter #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .ZERO_REG_EN(1'b1)) u_a (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(a_req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(a_req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .write_reg_address(a_addr), .data(a_data), .reg_write(a_reg_write),
    .grant_id(a_grant_id), .pending(a_pending)
  );

  regfile_write_arbiter #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .ZERO_REG_EN(1'b0)) u_b (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(b_req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(b_req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .write_reg_address(b_addr), .data(b_data), .reg_write(b_reg_write),
    .grant_id(b_grant_id), .pending(b_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic push_both(input logic [4:0] addr, input logic [63:0] d, input logic id);
    wr_t w;
    w.addr = addr; w.data = d; w.id = id;
    q_a.push_back(w);
    q_b.push_back(w);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitors: every reg_write pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (a_reg_write) begin
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_write got addr=%0d data=%0h exp none", a_addr, a_data);
      end else begin
        wr_t e;
        e = q_a.pop_front();
        check("a_wr_addr", 64'(a_addr), 64'(e.addr));
        check("a_wr_data", a_data, e.data);
        check("a_wr_id", 64'(a_grant_id), 64'(e.id));
      end
      mem_a[a_addr] = a_data;
    end
  end

  always @(negedge clk) begin
    if (b_reg_write) begin
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_write got addr=%0d data=%0h exp none", b_addr, b_data);
      end else begin
        wr_t e;
        e = q_b.pop_front();
        check("b_wr_addr", 64'(b_addr), 64'(e.addr));
        check("b_wr_data", b_data, e.data);
        check("b_wr_id", 64'(b_grant_id), 64'(e.id));
      end
      mem_b[b_addr] = b_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int i0, i1;
    for (int r = 0; r < 32; r++) begin
      mem_a[r] = '0;
      mem_b[r] = '0;
    end

    // 1. reset held with both requesters valid
    reset = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 64'd100;
    req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 64'd200;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_reg_write", 64'(a_reg_write), 64'd0);
    check("rst_pending", 64'(a_pending), 64'd0);
    check("rst_ready0", 64'(a_req0_ready), 64'd0);
    check("rst_ready1", 64'(a_req1_ready), 64'd0);
    check("rst_addr", 64'(a_addr), 64'd0);
    check("rst_data", a_data, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    push_both(5'd1, 64'd100, 1'b0);
    push_both(5'd2, 64'd200, 1'b1);
    @(negedge clk);
    check("post_rst_ready0", 64'(a_req0_ready), 64'd1);
    check("post_rst_ready1", 64'(a_req1_ready), 64'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    idle(4);

    // 2. single req0 write, pending window of two cycles
    req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 64'd43;
    push_both(5'd9, 64'd43, 1'b0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    check("p9_slot", 64'(a_pending), 64'h200);
    @(negedge clk);
    check("p9_issue", 64'(a_pending), 64'h200);
    @(negedge clk);
    check("p9_clear", 64'(a_pending), 64'h0);
    @(posedge clk); #1;

    // req1-only write so that req0 wins the next tie
    req1_valid = 1'b1; req1_addr = 5'd10; req1_data = 64'd55;
    push_both(5'd10, 64'd55, 1'b1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    idle(4);

    // 3. simultaneous accept, issued back to back
    req0_valid = 1'b1; req0_addr = 5'd16; req0_data = 64'd3;
    req1_valid = 1'b1; req1_addr = 5'd4;  req1_data = 64'd7;
    push_both(5'd16, 64'd3, 1'b0);
    push_both(5'd4, 64'd7, 1'b1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    check("p_both_held", 64'(a_pending), 64'h0001_0010);
    @(negedge clk);
    check("p_first_issue", 64'(a_pending), 64'h0001_0010);
    @(negedge clk);
    check("p_second_issue", 64'(a_pending), 64'h0000_0010);
    @(negedge clk);
    check("p_done", 64'(a_pending), 64'h0);
    @(posedge clk); #1;
    idle(2);

    // 4. constant contention for 8 edges: req0 accepted at 1,2,4,6,8; req1 at 1,3,5,7
    for (int k = 0; k < 5; k++) begin
      push_both(5'(20 + k), 64'h1000 + 64'(k), 1'b0);
      if (k < 4) push_both(5'(24 + k), 64'h2000 + 64'(k), 1'b1);
    end
    i0 = 0; i1 = 0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      req0_addr = 5'(20 + i0); req0_data = 64'h1000 + 64'(i0);
      req1_addr = 5'(24 + i1); req1_data = 64'h2000 + 64'(i1);
      @(negedge clk);
      check("cont_ready0", 64'(a_req0_ready), 64'((e == 1) || (e % 2 == 0)));
      check("cont_ready1", 64'(a_req1_ready), 64'((e == 1) || (e % 2 == 1)));
      @(posedge clk); #1;
      if ((e == 1) || (e % 2 == 0)) i0++;
      if ((e == 1) || (e % 2 == 1)) i1++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    idle(12);

    // 5. write to register 31: discarded by u_a, issued by u_b
    req1_valid = 1'b1; req1_addr = 5'd31; req1_data = 64'd5;
    begin
      wr_t w;
      w.addr = 5'd31; w.data = 64'd5; w.id = 1'b1;
      q_b.push_back(w);
    end
    @(negedge clk);
    check("xzr_ready", 64'(a_req1_ready), 64'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(negedge clk);
    check("xzr_a_pending", 64'(a_pending), 64'h0);
    check("xzr_b_pending", 64'(b_pending), 64'h8000_0000);
    @(negedge clk);
    check("xzr_a_pending2", 64'(a_pending), 64'h0);
    check("xzr_a_no_write", 64'(a_reg_write), 64'd0);
    @(posedge clk); #1;
    idle(3);

    // 6. reset while both slots are full discards both writes
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 64'd50;
    req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 64'd60;
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("r6_held", 64'(a_pending), 64'h60);
    check("r6_ready0", 64'(a_req0_ready), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("r6_a_no_write", 64'(a_reg_write), 64'd0);
      check("r6_a_pending", 64'(a_pending), 64'h0);
      check("r6_b_no_write", 64'(b_reg_write), 64'd0);
    end
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_addr = 5'd2; req0_data = 64'd11;
    push_both(5'd2, 64'd11, 1'b0);
    @(posedge clk); #1;
    req0_valid = 1'b0;

    for (int c = 0; c < 20 && (q_a.size() != 0 || q_b.size() != 0); c++) @(posedge clk);
    idle(2);
    check("a_queue_drained", 64'(q_a.size()), 64'd0);
    check("b_queue_drained", 64'(q_b.size()), 64'd0);
    check("rf_r9", mem_a[9], 64'd43);
    check("rf_r16", mem_a[16], 64'd3);
    check("rf_r4", mem_a[4], 64'd7);
    check("rf_r2", mem_a[2], 64'd11);
    check("rf_r5_discarded", mem_a[5], 64'd0);
    check("rf_b_r31", mem_b[31], 64'd5);
    check("rf_a_r31", mem_a[31], 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
